// File: rtl/mem_resp_queue_stage_if.sv
// mem_resp_queue_stage_if
//   Bundles every signal of the memory response queue stage except clock and
//   reset. The stage sits between M1 and WB:
//     in_*     : op offered by M1 (valid/ready handshake)
//     flush    : discard every queued op
//     resp_*   : in-order DCache load data
//     out_*    : completed head op offered to WB (valid/ready handshake)
//     fwd_*    : youngest completed RF-writing entry, for bypass to earlier stages
//     resp_err : sticky flag for an unexpected response
//     count    : queue occupancy
//   Modport master is the environment side (M1, DCache, WB).
//   Modport slave is the queue stage itself.
interface mem_resp_queue_stage_if #(
  parameter int CNT_W = 3
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_pc;
  logic             in_gr_we;
  logic [4:0]       in_dest;
  logic             in_res_from_mem;
  logic [2:0]       in_mem_op;
  logic [31:0]      in_alu_result;
  logic [31:0]      in_rt_value;
  logic             in_is_mfc0;
  logic [31:0]      in_cp0_data;
  logic             in_ex;
  logic             flush;
  logic             resp_valid;
  logic [31:0]      resp_rdata;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_pc;
  logic             out_gr_we;
  logic [4:0]       out_dest;
  logic [31:0]      out_result;
  logic             out_ex;
  logic [4:0]       fwd_dest;
  logic [31:0]      fwd_result;
  logic             resp_err;
  logic [CNT_W-1:0] count;

  modport master (
    output in_valid, in_pc, in_gr_we, in_dest, in_res_from_mem, in_mem_op,
           in_alu_result, in_rt_value, in_is_mfc0, in_cp0_data, in_ex,
           flush, resp_valid, resp_rdata, out_ready,
    input  in_ready, out_valid, out_pc, out_gr_we, out_dest, out_result, out_ex,
           fwd_dest, fwd_result, resp_err, count
  );

  modport slave (
    input  in_valid, in_pc, in_gr_we, in_dest, in_res_from_mem, in_mem_op,
           in_alu_result, in_rt_value, in_is_mfc0, in_cp0_data, in_ex,
           flush, resp_valid, resp_rdata, out_ready,
    output in_ready, out_valid, out_pc, out_gr_we, out_dest, out_result, out_ex,
           fwd_dest, fwd_result, resp_err, count
  );
endinterface

// File: rtl/mem_resp_queue_stage.sv
// mem_resp_queue_stage
//   In-order queue of up to DEPTH memory-stage ops. Loads wait in the queue
//   until their DCache response arrives, are then aligned and extended
//   (LW/LB/LBU/LH/LHU/LWL/LWR), and drain to WB in program order.
//   Ports:
//     clk   : clock
//     reset : synchronous, active-high; overrides flush
//     bus   : mem_resp_queue_stage_if.slave (M1 input, DCache response,
//             WB output, forwarding view, resp_err, count)
//   Parameters:
//     DEPTH : entries, power of two, >= 2
//     CNT_W : occupancy counter width, log2(DEPTH)+1
//   Optional feature:
//     MEM_RESP_BYPASS_EN : when defined, a response for a waiting head entry
//     is presented on out_* in the same cycle (0-cycle load latency).
module mem_resp_queue_stage #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic                        clk,
  input  logic                        reset,
  mem_resp_queue_stage_if.slave       bus
);
  localparam int PTR_W  = CNT_W - 1;
  // Repeated flushes can stack outstanding responses beyond DEPTH.
  localparam int DROP_W = CNT_W + 4;

  typedef struct packed {
    logic [31:0] pc;
    logic        gr_we;
    logic [4:0]  dest;
    logic [2:0]  mem_op;
    logic [1:0]  off;
    logic [31:0] rt;
    logic [31:0] result;
    logic        ex;
    logic        done;
  } entry_t;

  entry_t            q [DEPTH];
  logic [PTR_W-1:0]  head, tail, resp_ptr;
  logic [CNT_W-1:0]  count_q, count_n, wait_cnt, wait_n;
  logic [DROP_W-1:0] drop_cnt, drop_n;
  logic              resp_err_q;
  logic              resp_found, fwd_found;
  logic              enq, enq_wait, deq, resp_match, fill_en, resp_stray;
  logic              head_done, bypass_hit, out_valid_c;
  logic [31:0]       fill_result, fwd_result_c;
  logic [4:0]        fwd_dest_c;
  entry_t            new_entry;

  function automatic logic [31:0] align_load(input logic [2:0]  op,
                                             input logic [1:0]  off,
                                             input logic [31:0] rdata,
                                             input logic [31:0] rt);
    logic [7:0]  b;
    logic [15:0] h;
    b = rdata[{off, 3'b000} +: 8];
    h = off[1] ? rdata[31:16] : rdata[15:0];
    case (op)
      3'd1:    align_load = {{24{b[7]}}, b};
      3'd2:    align_load = {24'd0, b};
      3'd3:    align_load = off[0] ? 32'd0 : {{16{h[15]}}, h};
      3'd4:    align_load = off[0] ? 32'd0 : {16'd0, h};
      3'd5: begin
        case (off)
          2'd0:    align_load = {rdata[7:0], rt[23:0]};
          2'd1:    align_load = {rdata[15:0], rt[15:0]};
          2'd2:    align_load = {rdata[23:0], rt[7:0]};
          default: align_load = rdata;
        endcase
      end
      3'd6: begin
        case (off)
          2'd0:    align_load = rdata;
          2'd1:    align_load = {rt[31:24], rdata[31:8]};
          2'd2:    align_load = {rt[31:16], rdata[31:16]};
          default: align_load = {rt[31:8], rdata[31:24]};
        endcase
      end
      default: align_load = rdata;
    endcase
  endfunction

  // Oldest waiting entry, scanning from head. Responses are in order, so this
  // is where the next response belongs; it acts as the response pointer.
  always_comb begin
    resp_ptr   = head;
    resp_found = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!resp_found && (CNT_W'(i) < count_q) && !q[head + PTR_W'(i)].done) begin
        resp_ptr   = head + PTR_W'(i);
        resp_found = 1'b1;
      end
    end
  end

  // Youngest completed entry that writes the RF, scanning back from tail.
  always_comb begin
    fwd_found    = 1'b0;
    fwd_dest_c   = 5'd0;
    fwd_result_c = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!fwd_found && (CNT_W'(i) < count_q) &&
          q[tail - PTR_W'(i + 1)].done && q[tail - PTR_W'(i + 1)].gr_we) begin
        fwd_found    = 1'b1;
        fwd_dest_c   = q[tail - PTR_W'(i + 1)].dest;
        fwd_result_c = q[tail - PTR_W'(i + 1)].result;
      end
    end
  end

  // Handshakes, response routing and counter next-state.
  always_comb begin
    enq         = bus.in_valid && (count_q < CNT_W'(DEPTH)) && !bus.flush;
    enq_wait    = enq && bus.in_res_from_mem && !bus.in_ex;
    // A response belongs to a live entry only once earlier flushes are paid off.
    resp_match  = bus.resp_valid && (drop_cnt == '0) && (wait_cnt != '0);
    resp_stray  = bus.resp_valid && (drop_cnt == '0) && (wait_cnt == '0);
    fill_en     = resp_match && !bus.flush;
    fill_result = align_load(q[resp_ptr].mem_op, q[resp_ptr].off,
                             bus.resp_rdata, q[resp_ptr].rt);
    head_done   = q[head].done;
`ifdef MEM_RESP_BYPASS_EN
    // fill_en with a waiting head means resp_ptr is the head itself.
    bypass_hit  = fill_en && !head_done;
`else
    bypass_hit  = 1'b0;
`endif
    out_valid_c = (count_q != '0) && (head_done || bypass_hit);
    deq         = out_valid_c && bus.out_ready;

    new_entry        = '0;
    new_entry.pc     = bus.in_pc;
    new_entry.gr_we  = bus.in_gr_we;
    new_entry.dest   = bus.in_dest;
    new_entry.mem_op = bus.in_mem_op;
    new_entry.off    = bus.in_alu_result[1:0];
    new_entry.rt     = bus.in_rt_value;
    new_entry.result = bus.in_is_mfc0 ? bus.in_cp0_data : bus.in_alu_result;
    new_entry.ex     = bus.in_ex;
    new_entry.done   = !(bus.in_res_from_mem && !bus.in_ex);

    count_n = bus.flush ? '0 : count_q + CNT_W'(enq) - CNT_W'(deq);
    wait_n  = bus.flush ? '0 : wait_cnt + CNT_W'(enq_wait) - CNT_W'(fill_en);

    drop_n = drop_cnt;
    if (bus.resp_valid && (drop_cnt != '0)) drop_n = drop_cnt - 1'b1;
    // On flush every waiting entry still owes a response, minus one that
    // arrives in the flush cycle itself for a live entry.
    if (bus.flush) drop_n = drop_n + DROP_W'(wait_cnt) - DROP_W'(resp_match);
  end

  // Entry storage, pointers and counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      head       <= '0;
      tail       <= '0;
      resp_err_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
    end else begin
      if (bus.flush) begin
        head <= '0;
        tail <= '0;
      end else begin
        if (fill_en) begin
          q[resp_ptr].result <= fill_result;
          q[resp_ptr].done   <= 1'b1;
        end
        if (enq) begin
          q[tail] <= new_entry;
          tail    <= tail + 1'b1;
        end
        if (deq) head <= head + 1'b1;
      end
      if (resp_stray) resp_err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q  <= '0;
      wait_cnt <= '0;
      drop_cnt <= '0;
    end else begin
      count_q  <= count_n;
      wait_cnt <= wait_n;
      drop_cnt <= drop_n;
    end
  end

  assign bus.in_ready   = (count_q < CNT_W'(DEPTH));
  assign bus.out_valid  = out_valid_c;
  assign bus.out_pc     = out_valid_c ? q[head].pc    : 32'd0;
  assign bus.out_gr_we  = out_valid_c ? q[head].gr_we : 1'b0;
  assign bus.out_dest   = out_valid_c ? q[head].dest  : 5'd0;
  assign bus.out_ex     = out_valid_c ? q[head].ex    : 1'b0;
  assign bus.out_result = !out_valid_c ? 32'd0 :
                          head_done    ? q[head].result : fill_result;
  assign bus.fwd_dest   = fwd_dest_c;
  assign bus.fwd_result = fwd_result_c;
  assign bus.resp_err   = resp_err_q;
  assign bus.count      = count_q;
endmodule
